ifq_line_unpacker: RTL
======================

Name: ifq_line_unpacker

Overview:
- Read-side consumer of the instruction fetch queue (IFQ) circular buffer.
- Each cycle with data available, it presents one instruction word to the dispatch stage over a valid/ready handshake.
- It pulls one LENGTH-bit fetch line from the buffer, then issues the line's INSTR_W-bit words in order, with the matching PC.
- It pulls the next line back-to-back, with no bubble, and honours the common pipeline flush with a redirect PC.

Parameters:
- LENGTH, 128, fetch line width in bits; must equal the buffer's LENGTH.
- INSTR_W, 32, instruction width in bits; LENGTH/INSTR_W (WORDS) must be a power of two >= 2.
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  in  1  clock, rising-edge active.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  pipeline flush/redirect pulse; the same signal also drives the buffer's flush.
- flush_pc  in  32  redirect PC, sampled when flush=1.
- buf_empty  in  1  buffer empty flag.
- buf_data_read  in  LENGTH  head entry of the buffer, valid combinationally while buf_empty=0.
- buf_pull  out  1  pull strobe to the buffer; the buffer advances its read_ptr at the next rising edge.
- instr_valid  out  1  instr/instr_pc are valid.
- instr_ready  in  1  dispatch accepts the word this cycle.
- instr  out  INSTR_W  current instruction word.
- instr_pc  out  32  PC of instr.

Behaviour:
- Registers:
  - line_q: held line.
  - idx_q: word index, log2(WORDS) bits.
  - pc_q.
  - state: IDLE or ACTIVE.
- Reset values:
  - state=IDLE, line_q=0, idx_q=RESET_PC[log2(LENGTH/8)-1:2], pc_q=RESET_PC.
  - Outputs: instr_valid=0, buf_pull=0, instr=0, instr_pc=RESET_PC.
- Output logic:
  - instr = line_q word idx_q; word 0 is bits [INSTR_W-1:0].
  - instr_pc = pc_q.
  - instr_valid = (state==ACTIVE).
- Handshake:
  - fire = instr_valid & instr_ready.
  - On fire: pc_q += 4, and idx_q += 1 (wraps to 0 modulo WORDS).
  - instr and instr_pc stay stable while instr_valid=1 and instr_ready=0.
- last = (idx_q == WORDS-1).
- Load condition:
  - load = !flush & !buf_empty & ((state==IDLE) | (fire & last)).
  - buf_pull = load, combinational, pulsed in the same cycle as the capture.
  - On load: line_q <= buf_data_read and state <= ACTIVE.
- Transitions:
  - IDLE -> ACTIVE on load. Latency: buffer non-empty in cycle N gives instr_valid=1 in cycle N+1.
  - ACTIVE & fire & last & buf_empty -> IDLE.
  - ACTIVE & fire & last & !buf_empty -> ACTIVE with the new line; no bubble.
  - ACTIVE & fire & !last -> ACTIVE.
- Flush has highest priority over load and fire:
  - Next state: state <= IDLE, pc_q <= {flush_pc[31:2],2'b00}, idx_q <= flush_pc[log2(LENGTH/8)-1:2].
  - buf_pull=0 in the flush cycle.
  - instr_valid drops the next cycle.
  - The next load after flush starts at the redirect word offset; earlier words of that line are skipped.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); no pull is issued while rst=1.
- flush_pc[1:0] is ignored (forced to 0).
- PC wraps modulo 2^32.

Optional Feature:
- Macro: IFQ_STARVE_CNT_EN.
- Defined:
  - Adds output port starve_cnt, 16 bits.
  - Increments on every cycle with instr_ready=1 & instr_valid=0.
  - Saturates at 16'hFFFF.
  - Cleared only by rst; flush does not clear it.
- Not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then buffer holds one line {32'h33,32'h22,32'h11,32'h00} with instr_ready=1 -> buf_pull for one cycle; instr 0x00,0x11,0x22,0x33 on 4 consecutive cycles with instr_pc 0,4,8,C; then instr_valid=0 and state IDLE.
- Two lines queued, instr_ready=1 -> buf_pull asserted in the same cycle as the word-3 fire; 8 consecutive valid words with no bubble; PCs 0x00..0x1C.
- instr_ready toggled 1,0,0,1 mid-line -> instr/instr_pc held stable during stall; no word skipped or duplicated; no buf_pull until word 3 fires.
- flush with flush_pc=0x1008 while ACTIVE at idx 1 -> next cycle instr_valid=0; next line load yields first instr = word 2 with pc 0x1008, then word 3 at 0x100C, then pull.
- flush asserted in the same cycle as a would-be load (buf_empty=0, last word firing) -> buf_pull=0, state IDLE, redirect applied.
- With IFQ_STARVE_CNT_EN: buffer empty and instr_ready=1 for 10 cycles after reset release -> starve_cnt=10; flush leaves it at 10; rst clears it to 0.

Source files
------------

// File: rtl/ifq_line_unpacker.sv
// ---------------------------------------------------------------------------
// ifq_line_unpacker
//
// Reads the instruction fetch queue (IFQ) circular buffer. It takes one
// LENGTH-bit fetch line from the buffer head, then hands its INSTR_W-bit
// words to dispatch in order, one per accepted valid/ready handshake, each
// with its PC. When the last word of a line is accepted and the buffer holds
// another line, that line is captured in the same cycle, so there is no
// bubble between lines. A flush drops the held line and redirects the PC.
// The low PC bits select the first word issued from the next line, so the
// words before a redirect target are skipped.
//
// Optional feature (macro IFQ_STARVE_CNT_EN): adds the starve_cnt output.
// It is a saturating count of cycles in which dispatch was ready but no word
// was offered. Only rst clears it.
//
// Ports:
//   clk            clock, rising-edge active
//   rst            asynchronous active-high reset
//   flush          pipeline flush / redirect pulse (also flushes the buffer)
//   flush_pc       redirect PC, sampled while flush=1 (bits [1:0] ignored)
//   buf_empty      buffer empty flag
//   buf_data_read  buffer head line, valid while buf_empty=0
//   buf_pull       pop strobe; the buffer advances at the next rising edge
//   instr_valid    instr / instr_pc hold a word for dispatch
//   instr_ready    dispatch accepts the offered word this cycle
//   instr          current instruction word
//   instr_pc       PC of instr
//   starve_cnt     (IFQ_STARVE_CNT_EN only) ready-but-starved cycle count
// ---------------------------------------------------------------------------
module ifq_line_unpacker #(
    parameter int          LENGTH   = 128,
    parameter int          INSTR_W  = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [31:0]        flush_pc,
    input  logic               buf_empty,
    input  logic [LENGTH-1:0]  buf_data_read,
    output logic               buf_pull,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        instr_pc
`ifdef IFQ_STARVE_CNT_EN
    ,
    output logic [15:0]        starve_cnt
`endif
);

    localparam int WORDS = LENGTH / INSTR_W;
    localparam int IDX_W = $clog2(WORDS);

    // Word offset of RESET_PC inside a line. Bits [1:0] are the byte offset,
    // so the word index starts at bit 2.
    localparam logic [IDX_W-1:0] RESET_IDX = RESET_PC[IDX_W+1:2];

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t              state;
    logic [LENGTH-1:0]   line_q;
    logic [IDX_W-1:0]    idx_q;
    logic [31:0]         pc_q;

    logic                fire;
    logic                last;
    logic                load;

    // A redirect target is always word aligned, so the byte-offset bits of
    // flush_pc carry no information.
    logic                unused_flush_bits;
    assign unused_flush_bits = ^flush_pc[1:0];

    // Handshake and line-boundary decode. A new line is taken either when
    // nothing is held, or when the last held word leaves this cycle, so that
    // the next line follows without a gap. A flush blocks the load because
    // the buffer head is about to be discarded along with it.
    always_comb begin
        instr_valid = (state == ACTIVE);
        fire        = instr_valid & instr_ready;
        last        = (idx_q == IDX_W'(WORDS - 1));
        load        = !flush && !buf_empty && ((state == IDLE) || (fire && last));
        buf_pull    = load && !rst;
    end

    // The offered word is a plain mux of the held line by the word index.
    // Word 0 sits in the least significant bits.
    always_comb begin
        instr    = line_q[int'(idx_q) * INSTR_W +: INSTR_W];
        instr_pc = pc_q;
    end

    // Main sequencer. Flush wins over everything: it drops back to IDLE and
    // loads the redirect PC, and its word offset becomes the start index
    // for the next captured line. Otherwise each accepted word advances the
    // PC and the word index. The index wraps to 0 after the last word, which
    // matches the start of a line captured in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            line_q <= '0;
            idx_q  <= RESET_IDX;
            pc_q   <= RESET_PC;
        end else if (flush) begin
            state  <= IDLE;
            pc_q   <= {flush_pc[31:2], 2'b00};
            idx_q  <= flush_pc[IDX_W+1:2];
        end else begin
            if (fire) begin
                pc_q  <= pc_q + 32'd4;
                idx_q <= idx_q + IDX_W'(1);
            end
            if (load) begin
                line_q <= buf_data_read;
                state  <= ACTIVE;
            end else if (fire && last) begin
                state  <= IDLE;
            end
        end
    end

`ifdef IFQ_STARVE_CNT_EN
    // Starvation counter: counts cycles in which dispatch was ready but
    // nothing was offered. It sticks at all-ones, and a flush does not clear
    // it, so it measures the whole run since reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (instr_ready && !instr_valid && (starve_cnt != 16'hFFFF)) begin
            starve_cnt <= starve_cnt + 16'd1;
        end
    end
`else
    // Without the starvation counter there is no extra state to keep.
`endif

endmodule
